// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter
//   Arbitrates instruction-cache and data-cache line requests onto a single
//   next-level cache request port. Each requester owns a private miss FIFO.
//   A two-state FSM (IDLE/REQ) pops one head per transaction, using
//   round-robin selection. It holds the request stable until acknowledged.
//
// Handshake rules:
//   Request side: a request is taken on a rising edge where valid and ready
//   are both high. ready is NOT full, and ready is forced low during reset.
//   Next-level side: l2_req/l2_addr/l2_src stay stable until l2_ack is
//   sampled high. At most one transaction completes every two cycles.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   ic_valid/ic_addr     instruction cache request, ic_ready back-pressure
//   dc_valid/dc_addr     data cache request, dc_ready back-pressure
//   l2_req/l2_addr/l2_src  next-level request (src 0 = ic, 1 = dc)
//   l2_ack               next-level accept
//   ic_grants/dc_grants  saturating completed-transaction counters
//   fsm_state            debug view of the FSM (0 = IDLE, 1 = REQ)

// Per-requester miss queue. Push and pop are gated internally,
// so a push while full or a pop while empty is ignored.
module l2_port_fifo #(
    parameter int W     = 26,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_en;
    logic          pop_en;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + PW'(1);
            if (push_en && !pop_en)      count <= count + CW'(1);
            else if (pop_en && !push_en) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= din;
    end
endmodule

module l2_port_arbiter #(
    parameter int ADDR_W     = 26,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_valid,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ready,
    input  logic              dc_valid,
    input  logic [ADDR_W-1:0] dc_addr,
    output logic              dc_ready,
    output logic              l2_req,
    output logic [ADDR_W-1:0] l2_addr,
    output logic              l2_src,
    input  logic              l2_ack,
    output logic [31:0]       ic_grants,
    output logic [31:0]       dc_grants,
    output logic              fsm_state
);
    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t            state;
    state_t            state_next;
    logic              ic_full, ic_empty, dc_full, dc_empty;
    logic [ADDR_W-1:0] ic_head, dc_head;
    logic              ic_pop, dc_pop;
    logic              grant_dc;
    logic              grant;
    logic              complete;
    // Source of the most recent completed grant; reset to ic so dc wins first.
    logic              last_dc;

    assign ic_ready  = !reset && !ic_full;
    assign dc_ready  = !reset && !dc_full;
    assign fsm_state = state;

    l2_port_fifo #(.W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_ic_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ic_valid && ic_ready),
        .din   (ic_addr),
        .pop   (ic_pop),
        .dout  (ic_head),
        .full  (ic_full),
        .empty (ic_empty)
    );

    l2_port_fifo #(.W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_dc_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (dc_valid && dc_ready),
        .din   (dc_addr),
        .pop   (dc_pop),
        .dout  (dc_head),
        .full  (dc_full),
        .empty (dc_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (!ic_empty || !dc_empty) state_next = REQ;
            REQ:  if (l2_ack)                 state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / control logic
    always_comb begin
        grant    = 1'b0;
        grant_dc = 1'b0;
        ic_pop   = 1'b0;
        dc_pop   = 1'b0;
        complete = 1'b0;
        l2_req   = (state == REQ);
        if (state == IDLE && (!ic_empty || !dc_empty)) begin
            grant    = 1'b1;
            // dc wins when it is the only one waiting, or when both wait and
            // ic was the last source served.
            grant_dc = !dc_empty && (ic_empty || !last_dc);
            dc_pop   = grant_dc;
            ic_pop   = !grant_dc;
        end
        if (state == REQ) complete = l2_ack;
    end

    // Request payload, round-robin pointer and grant counters
    always_ff @(posedge clk) begin
        if (reset) begin
            l2_addr   <= '0;
            l2_src    <= 1'b0;
            last_dc   <= 1'b0;
            ic_grants <= '0;
            dc_grants <= '0;
        end else begin
            if (grant) begin
                l2_addr <= grant_dc ? dc_head : ic_head;
                l2_src  <= grant_dc;
            end
            if (complete) begin
                last_dc <= l2_src;
                if (l2_src) begin
                    if (dc_grants != 32'hFFFF_FFFF) dc_grants <= dc_grants + 32'd1;
                end else begin
                    if (ic_grants != 32'hFFFF_FFFF) ic_grants <= ic_grants + 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_l2_port_arbiter.sv
module tb_l2_port_arbiter;
    localparam int ADDR_W = 26;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ic_valid = 1'b0;
    logic [ADDR_W-1:0] ic_addr = '0;
    logic              ic_ready;
    logic              dc_valid = 1'b0;
    logic [ADDR_W-1:0] dc_addr = '0;
    logic              dc_ready;
    logic              l2_req;
    logic [ADDR_W-1:0] l2_addr;
    logic              l2_src;
    logic              l2_ack = 1'b0;
    logic [31:0]       ic_grants;
    logic [31:0]       dc_grants;
    logic              fsm_state;

    // Scoreboard entry: {src, addr}
    logic [ADDR_W:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    l2_port_arbiter #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .ic_valid  (ic_valid),
        .ic_addr   (ic_addr),
        .ic_ready  (ic_ready),
        .dc_valid  (dc_valid),
        .dc_addr   (dc_addr),
        .dc_ready  (dc_ready),
        .l2_req    (l2_req),
        .l2_addr   (l2_addr),
        .l2_src    (l2_src),
        .l2_ack    (l2_ack),
        .ic_grants (ic_grants),
        .dc_grants (dc_grants),
        .fsm_state (fsm_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ic_valid = 1'b0;
        dc_valid = 1'b0;
        l2_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Wait until every expected transaction has been observed.
    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard monitor: a transaction completes on the edge after a
    // negedge where l2_req and l2_ack are both high.
    always @(negedge clk) begin
        if (!reset && l2_req && l2_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_txn", {6'd0, l2_src, l2_addr}, 32'hDEAD);
            end else begin
                logic [ADDR_W:0] e;
                e = exp_q.pop_front();
                check("txn_src", 32'(l2_src), 32'(e[ADDR_W]));
                check("txn_addr", 32'(l2_addr), 32'(e[ADDR_W-1:0]));
            end
        end
    end

    initial begin
        int n;
        // ---- Reset state ----
        tick();
        tick();
        check("rst_l2_req", 32'(l2_req), 32'd0);
        check("rst_ic_ready", 32'(ic_ready), 32'd0);
        check("rst_dc_ready", 32'(dc_ready), 32'd0);
        check("rst_l2_addr", 32'(l2_addr), 32'd0);
        check("rst_fsm", 32'(fsm_state), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_ic_grants", ic_grants, 32'd0);
        check("rst_dc_grants", dc_grants, 32'd0);
        check("post_rst_ic_ready", 32'(ic_ready), 32'd1);
        check("post_rst_dc_ready", 32'(dc_ready), 32'd1);

        // ---- Single dc request ----
        dc_valid = 1'b1;
        dc_addr = 26'h0ABCDEF;
        exp_q.push_back({1'b1, 26'h0ABCDEF});
        tick();
        dc_valid = 1'b0;
        check("single_req_before", 32'(l2_req), 32'd0);
        tick();
        check("single_req_rise", 32'(l2_req), 32'd1);
        check("single_fsm_req", 32'(fsm_state), 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("single_hold_req", 32'(l2_req), 32'd1);
            check("single_hold_addr", 32'(l2_addr), 32'h0ABCDEF);
            check("single_hold_src", 32'(l2_src), 32'd1);
        end
        l2_ack = 1'b1;
        tick();
        l2_ack = 1'b0;
        check("single_req_fall", 32'(l2_req), 32'd0);
        check("single_dc_grants", dc_grants, 32'd1);
        check("single_ic_grants", ic_grants, 32'd0);

        // ---- Contention after reset: dc first, then ic ----
        do_reset();
        ic_valid = 1'b1;
        ic_addr = 26'h1;
        dc_valid = 1'b1;
        dc_addr = 26'h2;
        l2_ack = 1'b1;
        exp_q.push_back({1'b1, 26'h2});
        exp_q.push_back({1'b0, 26'h1});
        tick();
        ic_valid = 1'b0;
        dc_valid = 1'b0;
        check("cont_req_c0", 32'(l2_req), 32'd0);
        tick();
        check("cont_req_c1", 32'(l2_req), 32'd1);
        check("cont_src_c1", 32'(l2_src), 32'd1);
        tick();
        check("cont_req_c2", 32'(l2_req), 32'd0);
        tick();
        check("cont_req_c3", 32'(l2_req), 32'd1);
        check("cont_src_c3", 32'(l2_src), 32'd0);
        tick();
        check("cont_req_c4", 32'(l2_req), 32'd0);
        l2_ack = 1'b0;
        check("cont_ic_grants", ic_grants, 32'd1);
        check("cont_dc_grants", dc_grants, 32'd1);

        // ---- Full dc queue ----
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            dc_valid = 1'b1;
            dc_addr = ADDR_W'(i);
            check("full_ready_before_push", 32'(dc_ready), 32'd1);
            exp_q.push_back({1'b1, ADDR_W'(i)});
            tick();
        end
        check("full_ready_after5", 32'(dc_ready), 32'd0);
        dc_addr = 26'h6;
        tick();
        check("full_ready_6th", 32'(dc_ready), 32'd0);
        dc_valid = 1'b0;
        l2_ack = 1'b1;
        drain("full");
        l2_ack = 1'b0;
        tick();
        check("full_dc_grants", dc_grants, 32'd5);
        check("full_req_idle", 32'(l2_req), 32'd0);

        // ---- Wrap-around: 10 streamed ic requests ----
        do_reset();
        l2_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ic_valid = 1'b1;
            ic_addr = ADDR_W'(32'h100 + 32'(i) * 32'h1111);
            n = 0;
            while (!ic_ready && n < 20) begin
                tick();
                n++;
            end
            exp_q.push_back({1'b0, ic_addr});
            tick();
        end
        ic_valid = 1'b0;
        drain("wrap");
        l2_ack = 1'b0;
        tick();
        check("wrap_ic_grants", ic_grants, 32'd10);
        check("wrap_dc_grants", dc_grants, 32'd0);

        // ---- Reset mid-transaction with ack and a push presented ----
        ic_valid = 1'b1;
        ic_addr = 26'h55;
        tick();
        ic_valid = 1'b0;
        tick();
        check("midrst_in_req", 32'(l2_req), 32'd1);
        reset = 1'b1;
        l2_ack = 1'b1;
        dc_valid = 1'b1;
        dc_addr = 26'h77;
        tick();
        reset = 1'b0;
        l2_ack = 1'b0;
        dc_valid = 1'b0;
        tick();
        check("midrst_l2_req", 32'(l2_req), 32'd0);
        check("midrst_ic_grants", ic_grants, 32'd0);
        check("midrst_dc_grants", dc_grants, 32'd0);
        check("midrst_ic_ready", 32'(ic_ready), 32'd1);
        check("midrst_dc_ready", 32'(dc_ready), 32'd1);
        tick();
        check("midrst_push_discarded", 32'(l2_req), 32'd0);

        // ---- Stray ack in IDLE ----
        l2_ack = 1'b1;
        tick();
        tick();
        l2_ack = 1'b0;
        check("stray_l2_req", 32'(l2_req), 32'd0);
        check("stray_fsm", 32'(fsm_state), 32'd0);
        check("stray_ic_grants", ic_grants, 32'd0);
        check("stray_dc_grants", dc_grants, 32'd0);
        check("stray_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/l2_port_arbiter.md
L2_PORT_ARBITER -- requirements
Module: l2_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 26, next-level line address width (address bits 31:6).
REQ-002 Parameter FIFO_DEPTH, default 4, per-requester miss-queue depth (power of two, at least 2).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ic_valid  input  1  instruction cache presents a line-fill request.
REQ-006 ic_addr  input  ADDR_W  instruction cache line address.
REQ-007 ic_ready  output  1  instruction cache queue can accept a request.
REQ-008 dc_valid  input  1  data cache presents a line-fill or write-through request.
REQ-009 dc_addr  input  ADDR_W  data cache line address.
REQ-010 dc_ready  output  1  data cache queue can accept a request.
REQ-011 l2_req  output  1  request to the next-level cache.
REQ-012 l2_addr  output  ADDR_W  address of the current next-level request.
REQ-013 l2_src  output  1  source of the current request: 0 = instruction cache, 1 = data cache.
REQ-014 l2_ack  input  1  next-level cache accepts the current request.
REQ-015 ic_grants  output  32  count of completed instruction cache transactions.
REQ-016 dc_grants  output  32  count of completed data cache transactions.

Function
REQ-017 Each requester SHALL have a private FIFO of FIFO_DEPTH entries.
REQ-018 A push SHALL occur on an edge where valid and ready are both high.
REQ-019 ic_ready and dc_ready SHALL equal NOT full of the respective FIFO, and SHALL be 0 while reset is high.
REQ-020 FSM states SHALL be IDLE and REQ.
REQ-021 In IDLE with at least one FIFO non-empty, the block SHALL perform the following at the next edge:
  - pop the selected head;
  - load l2_addr and l2_src;
  - set l2_req = 1;
  - enter REQ.
REQ-022 Selection SHALL be round-robin: if both FIFOs are non-empty, grant the source not granted last; if only one is non-empty, grant it.
REQ-023 After reset, the round-robin pointer SHALL favour the data cache.
REQ-024 In REQ, l2_req, l2_addr and l2_src SHALL hold stable until l2_ack is sampled high.
REQ-025 On the edge that samples l2_ack high while in REQ, the block SHALL:
  - clear l2_req;
  - increment the matching grant counter;
  - update the round-robin pointer;
  - return to IDLE.
REQ-026 l2_ack sampled while in IDLE SHALL be ignored.
REQ-027 Latency: a request pushed into an empty queue while the FSM is IDLE SHALL assert l2_req at the first edge after the push edge.
REQ-028 Maximum throughput SHALL be one transaction per 2 cycles; there SHALL be no back-to-back REQ without an intervening IDLE cycle.
REQ-029 A push and a pop on the same FIFO in the same edge SHALL both take effect, with occupancy unchanged.
REQ-030 A full FIFO SHALL NOT accept a push, and the dropped-valid is the requester's responsibility.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and order SHALL be strict FIFO per source.
REQ-032 Grant counters SHALL saturate at 32'hFFFF_FFFF.
REQ-033 Addresses SHALL pass unmodified, with no duplicate merging.

Reset
REQ-034 reset high at an edge SHALL set the following:
  - FIFOs empty;
  - state IDLE;
  - l2_req = 0, l2_addr = 0, l2_src = 0;
  - both counters = 0;
  - round-robin pointer favouring the data cache.
REQ-035 Reset in REQ SHALL abandon the transaction: l2_req = 0 after that edge, and no counter increment even if l2_ack is high.
REQ-036 Pushes presented during reset SHALL be discarded.

Verification
REQ-037 Single request: dc_valid with dc_addr=26'h0ABCDEF for 1 cycle, l2_ack high 3 cycles after l2_req -> l2_req rises 1 edge after the push; l2_addr=26'h0ABCDEF and l2_src=1 held 3 cycles; dc_grants=1.
REQ-038 Contention: both valid in the same cycle (ic 26'h1, dc 26'h2), l2_ack tied high -> grant order dc then ic; l2_req high on alternate cycles; ic_grants=1, dc_grants=1.
REQ-039 Full queue: 5 consecutive dc pushes with l2_ack low -> dc_ready=0 after the 5th edge (1 entry in flight plus 4 queued); the 6th valid is not accepted; FIFO order 1..5 is preserved on drain.
REQ-040 Wrap-around: 10 ic requests streamed with l2_ack tied high -> all 10 addresses emerge in order; ic_grants=10.
REQ-041 Reset mid-transaction: reset asserted during REQ with l2_ack high in the same cycle -> l2_req=0, counters 0, ic_ready=dc_ready=1 one cycle after reset falls.
REQ-042 Stray ack: l2_ack pulsed in IDLE with empty queues -> no state change and counters unchanged.
